// File: rtl/coherence_pkg.sv
// Shared definitions for the two-core MSI coherence bus: bus request
// encodings, MSI line states and the bus controller state type.
package coherence_pkg;

  // Bus request kinds, as driven by a core and broadcast to its peer.
  localparam logic [1:0] BUS_INVALIDATE = 2'b00;
  localparam logic [1:0] BUS_WRITE_MISS = 2'b01;
  localparam logic [1:0] BUS_READ_MISS  = 2'b10;
  localparam logic [1:0] BUS_IDLE       = 2'b11;

  // MSI cache line states.
  localparam logic [1:0] I = 2'b00;
  localparam logic [1:0] S = 2'b01;
  localparam logic [1:0] M = 2'b10;

  // Bus controller transaction states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SNOOP = 3'd1,
    WB    = 3'd2,
    MEM   = 3'd3,
    DONE  = 3'd4
  } bus_state_t;

endpackage

// File: rtl/main_mem.sv
// 16x32 main memory: synchronous write with synchronous clear on reset,
// combinational read.
module main_mem (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_we,
  input  logic [3:0]  i_waddr,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_raddr,
  output logic [31:0] o_rdata
);

  logic [31:0] r_mem [16];

  // Clear every word on reset, otherwise perform the single write port.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < 16; k++) r_mem[k] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/snoop_bus_ctrl.sv
// Shared coherence bus and main-memory controller for two MSI cores.
// Round-robin arbitration of one request per core, snoop broadcast to the
// peer, write-backs (requester victim first, then snooper), and a fill
// either from the aborting snooper or from main memory.
//
// Handshake: a core presents req_kind != BUS_IDLE and holds it (with its
// address and victim data) until it sees its one-cycle done pulse; the fill
// outputs are valid only in that done cycle. Snooper responses are sampled
// during the single SNOOP cycle in which snoop_kind is non-idle for it.
module snoop_bus_ctrl
  import coherence_pkg::*;
#(
  parameter int MEM_LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req_kind,
  input  logic [7:0]  req_addr,
  input  logic [1:0]  cpu_wb,
  input  logic [7:0]  cpu_wb_addr,
  input  logic [63:0] cpu_wb_data,
  output logic [3:0]  snoop_kind,
  output logic [7:0]  snoop_addr,
  input  logic [1:0]  snoop_abort,
  input  logic [63:0] snoop_data,
  input  logic [1:0]  bus_wb,
  input  logic [7:0]  bus_wb_addr,
  input  logic [63:0] bus_wb_data,
  output logic [1:0]  done,
  output logic [31:0] fill_data,
  output logic        fill_from_cache,
  output logic [2:0]  dbg_state
);

  localparam logic [3:0] LAT_LAST = 4'(MEM_LATENCY - 1);

  bus_state_t  r_state;
  logic        r_req;
  logic [1:0]  r_kind;
  logic [3:0]  r_addr;
  logic        r_cpu_wb;
  logic [3:0]  r_cpu_wb_addr;
  logic [31:0] r_cpu_wb_data;
  logic        r_abort;
  logic [31:0] r_snoop_data;
  logic        r_bus_wb;
  logic [3:0]  r_bus_wb_addr;
  logic [31:0] r_bus_wb_data;
  logic [3:0]  r_cnt;
  logic        r_last_grant;
  logic [1:0]  r_mask;
  logic [3:0]  r_snoop_kind;
  logic [7:0]  r_snoop_addr;
  logic [1:0]  r_done;
  logic [31:0] r_fill_data;
  logic        r_fill_from_cache;

  // Arbitration: a core just served is masked for one IDLE cycle.
  logic [1:0]  w_elig;
  logic        w_gnt_id;
  logic        w_oth;
  assign w_elig[0] = (req_kind[1:0] != BUS_IDLE) && !r_mask[0];
  assign w_elig[1] = (req_kind[3:2] != BUS_IDLE) && !r_mask[1];
  assign w_gnt_id  = (w_elig == 2'b11) ? ~r_last_grant : w_elig[1];
  assign w_oth     = ~r_req;

  // Requester-side fields of the granted core.
  logic [1:0]  w_kind_g;
  logic [3:0]  w_addr_g;
  logic        w_cwb_g;
  logic [3:0]  w_cwb_addr_g;
  logic [31:0] w_cwb_data_g;
  assign w_kind_g     = w_gnt_id ? req_kind[3:2]      : req_kind[1:0];
  assign w_addr_g     = w_gnt_id ? req_addr[7:4]      : req_addr[3:0];
  assign w_cwb_g      = w_gnt_id ? cpu_wb[1]          : cpu_wb[0];
  assign w_cwb_addr_g = w_gnt_id ? cpu_wb_addr[7:4]   : cpu_wb_addr[3:0];
  assign w_cwb_data_g = w_gnt_id ? cpu_wb_data[63:32] : cpu_wb_data[31:0];

  // Snooper-side response of the non-requesting core.
  logic        w_s_abort;
  logic [31:0] w_s_data;
  logic        w_s_wb;
  logic [3:0]  w_s_wb_addr;
  logic [31:0] w_s_wb_data;
  assign w_s_abort   = w_oth ? snoop_abort[1]      : snoop_abort[0];
  assign w_s_data    = w_oth ? snoop_data[63:32]   : snoop_data[31:0];
  assign w_s_wb      = w_oth ? bus_wb[1]           : bus_wb[0];
  assign w_s_wb_addr = w_oth ? bus_wb_addr[7:4]    : bus_wb_addr[3:0];
  assign w_s_wb_data = w_oth ? bus_wb_data[63:32]  : bus_wb_data[31:0];

  // One write-back per WB cycle; the requester victim goes first so a
  // same-address snooper write-back lands last and wins.
  logic        w_mem_we;
  logic [3:0]  w_mem_waddr;
  logic [31:0] w_mem_wdata;
  logic [31:0] w_mem_rdata;
  logic        w_is_inv;
  assign w_mem_we    = (r_state == WB) && (r_cpu_wb || r_bus_wb);
  assign w_mem_waddr = r_cpu_wb ? r_cpu_wb_addr : r_bus_wb_addr;
  assign w_mem_wdata = r_cpu_wb ? r_cpu_wb_data : r_bus_wb_data;
  assign w_is_inv    = (r_kind == BUS_INVALIDATE);

  main_mem u_mem (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_we    (w_mem_we),
    .i_waddr (w_mem_waddr),
    .i_wdata (w_mem_wdata),
    .i_raddr (r_addr),
    .o_rdata (w_mem_rdata)
  );

  // Transaction FSM with registered bus, done and fill outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state           <= IDLE;
      r_req             <= 1'b0;
      r_kind            <= BUS_IDLE;
      r_addr            <= '0;
      r_cpu_wb          <= 1'b0;
      r_cpu_wb_addr     <= '0;
      r_cpu_wb_data     <= '0;
      r_abort           <= 1'b0;
      r_snoop_data      <= '0;
      r_bus_wb          <= 1'b0;
      r_bus_wb_addr     <= '0;
      r_bus_wb_data     <= '0;
      r_cnt             <= '0;
      r_last_grant      <= 1'b1;
      r_mask            <= 2'b00;
      r_snoop_kind      <= {BUS_IDLE, BUS_IDLE};
      r_snoop_addr      <= '0;
      r_done            <= 2'b00;
      r_fill_data       <= '0;
      r_fill_from_cache <= 1'b0;
    end else begin
      r_done <= 2'b00;
      r_mask <= 2'b00;
      case (r_state)
        IDLE: begin
          if (|w_elig) begin
            r_req         <= w_gnt_id;
            r_kind        <= w_kind_g;
            r_addr        <= w_addr_g;
            r_cpu_wb      <= w_cwb_g;
            r_cpu_wb_addr <= w_cwb_addr_g;
            r_cpu_wb_data <= w_cwb_data_g;
            r_snoop_kind  <= w_gnt_id ? {BUS_IDLE, w_kind_g} : {w_kind_g, BUS_IDLE};
            r_snoop_addr  <= w_gnt_id ? {4'h0, w_addr_g} : {w_addr_g, 4'h0};
            r_state       <= SNOOP;
          end
        end
        SNOOP: begin
          r_abort       <= w_s_abort;
          r_snoop_data  <= w_s_data;
          r_bus_wb      <= w_s_wb;
          r_bus_wb_addr <= w_s_wb_addr;
          r_bus_wb_data <= w_s_wb_data;
          r_snoop_kind  <= {BUS_IDLE, BUS_IDLE};
          r_snoop_addr  <= '0;
          if (r_cpu_wb || w_s_wb) begin
            r_state <= WB;
          end else if (w_is_inv || w_s_abort) begin
            r_state           <= DONE;
            r_done[r_req]     <= 1'b1;
            r_fill_data       <= w_is_inv ? 32'h0 : w_s_data;
            r_fill_from_cache <= !w_is_inv;
          end else begin
            r_state <= MEM;
            r_cnt   <= '0;
          end
        end
        WB: begin
          if (r_cpu_wb) r_cpu_wb <= 1'b0;
          else          r_bus_wb <= 1'b0;
          if (!(r_cpu_wb && r_bus_wb)) begin
            if (w_is_inv || r_abort) begin
              r_state           <= DONE;
              r_done[r_req]     <= 1'b1;
              r_fill_data       <= w_is_inv ? 32'h0 : r_snoop_data;
              r_fill_from_cache <= !w_is_inv;
            end else begin
              r_state <= MEM;
              r_cnt   <= '0;
            end
          end
        end
        MEM: begin
          if (r_cnt == LAT_LAST) begin
            r_state           <= DONE;
            r_done[r_req]     <= 1'b1;
            r_fill_data       <= w_mem_rdata;
            r_fill_from_cache <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        DONE: begin
          r_last_grant <= r_req;
          r_mask       <= r_req ? 2'b10 : 2'b01;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign snoop_kind      = r_snoop_kind;
  assign snoop_addr      = r_snoop_addr;
  assign done            = r_done;
  assign fill_data       = r_fill_data;
  assign fill_from_cache = r_fill_from_cache;
  assign dbg_state       = r_state;

endmodule

// File: tb/tb_snoop_bus_ctrl.sv
// Directed bench for snoop_bus_ctrl with MEM_LATENCY = 3.
module tb_snoop_bus_ctrl;
  import coherence_pkg::*;

  logic        clk;
  logic        rst;
  logic [3:0]  req_kind;
  logic [7:0]  req_addr;
  logic [1:0]  cpu_wb;
  logic [7:0]  cpu_wb_addr;
  logic [63:0] cpu_wb_data;
  logic [3:0]  snoop_kind;
  logic [7:0]  snoop_addr;
  logic [1:0]  snoop_abort;
  logic [63:0] snoop_data;
  logic [1:0]  bus_wb;
  logic [7:0]  bus_wb_addr;
  logic [63:0] bus_wb_data;
  logic [1:0]  done;
  logic [31:0] fill_data;
  logic        fill_from_cache;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  snoop_bus_ctrl #(.MEM_LATENCY(3)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_kind        (req_kind),
    .req_addr        (req_addr),
    .cpu_wb          (cpu_wb),
    .cpu_wb_addr     (cpu_wb_addr),
    .cpu_wb_data     (cpu_wb_data),
    .snoop_kind      (snoop_kind),
    .snoop_addr      (snoop_addr),
    .snoop_abort     (snoop_abort),
    .snoop_data      (snoop_data),
    .bus_wb          (bus_wb),
    .bus_wb_addr     (bus_wb_addr),
    .bus_wb_data     (bus_wb_data),
    .done            (done),
    .fill_data       (fill_data),
    .fill_from_cache (fill_from_cache),
    .dbg_state       (dbg_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ":done"}, 32'(done), 32'h0);
    check({tag, ":skind"}, 32'(snoop_kind), 32'hF);
    check({tag, ":saddr"}, 32'(snoop_addr), 32'h0);
    check({tag, ":fill"}, fill_data, 32'h0);
    check({tag, ":fc"}, 32'(fill_from_cache), 32'h0);
    check({tag, ":state"}, 32'(dbg_state), 32'(IDLE));
  endtask

  // Driver tasks
  task automatic set_victim(input int c, input logic wb, input logic [3:0] a, input logic [31:0] d);
    if (c == 0) begin
      cpu_wb[0] = wb; cpu_wb_addr[3:0] = a; cpu_wb_data[31:0] = d;
    end else begin
      cpu_wb[1] = wb; cpu_wb_addr[7:4] = a; cpu_wb_data[63:32] = d;
    end
  endtask

  task automatic set_snooper(input int c, input logic ab, input logic [31:0] sd,
                             input logic wb, input logic [3:0] a, input logic [31:0] d);
    if (c == 0) begin
      snoop_abort[0] = ab; snoop_data[31:0] = sd;
      bus_wb[0] = wb; bus_wb_addr[3:0] = a; bus_wb_data[31:0] = d;
    end else begin
      snoop_abort[1] = ab; snoop_data[63:32] = sd;
      bus_wb[1] = wb; bus_wb_addr[7:4] = a; bus_wb_data[63:32] = d;
    end
  endtask

  task automatic clear_side();
    cpu_wb = '0; cpu_wb_addr = '0; cpu_wb_data = '0;
    snoop_abort = '0; snoop_data = '0;
    bus_wb = '0; bus_wb_addr = '0; bus_wb_data = '0;
  endtask

  // One request from core c; latency counted in cycles from the edge the
  // request is driven after (that cycle is 0).
  task automatic run_txn(input string tag, input int c, input logic [1:0] kind,
                         input logic [3:0] a, input int exp_lat,
                         input logic [31:0] exp_fill, input logic exp_fc);
    int n;
    logic [3:0] sk;
    logic [7:0] sa;
    logic [3:0] exp_sk;
    logic [7:0] exp_sa;
    logic [31:0] exp_f;
    repeat (2) @(posedge clk);
    #1;
    if (c == 0) begin req_kind[1:0] = kind; req_addr[3:0] = a; end
    else        begin req_kind[3:2] = kind; req_addr[7:4] = a; end
    exp_q.push_back(exp_fill);
    exp_sk = (c == 0) ? {kind, BUS_IDLE} : {BUS_IDLE, kind};
    exp_sa = (c == 0) ? {a, 4'h0} : {4'h0, a};
    sk = 4'hF;
    sa = 8'h0;
    for (n = 0; n < 40; n++) begin
      @(negedge clk);
      if (n == 1) begin sk = snoop_kind; sa = snoop_addr; end
      if (done != 2'b00) break;
    end
    check({tag, ":lat"}, 32'(n), 32'(exp_lat));
    check({tag, ":skind"}, 32'(sk), 32'(exp_sk));
    check({tag, ":saddr"}, 32'(sa), 32'(exp_sa));
    check({tag, ":done"}, 32'(done), (c == 0) ? 32'h1 : 32'h2);
    exp_f = exp_q.pop_front();
    check({tag, ":fill"}, fill_data, exp_f);
    check({tag, ":fc"}, 32'(fill_from_cache), 32'(exp_fc));
    check({tag, ":skidle"}, 32'(snoop_kind), 32'hF);
    if (c == 0) req_kind[1:0] = BUS_IDLE;
    else        req_kind[3:2] = BUS_IDLE;
    @(negedge clk);
    check({tag, ":pulse"}, 32'(done), 32'h0);
  endtask

  // Stimulus
  initial begin
    int n0;
    int n1;
    logic [3:0] sk1;
    logic [3:0] sk2;
    logic [31:0] f1;
    logic saw_done;

    rst = 1'b1;
    req_kind = 4'hF;
    req_addr = '0;
    clear_side();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");

    // Simultaneous requests after reset: core 0 wins, core 1 follows.
    @(posedge clk);
    #1;
    req_kind = {BUS_WRITE_MISS, BUS_READ_MISS};
    req_addr = {4'd2, 4'd1};
    n0 = -1; n1 = -1; sk1 = '0; sk2 = '0; f1 = 32'hDEAD;
    for (int n = 0; n < 40 && n1 < 0; n++) begin
      @(negedge clk);
      if (n == 1) sk1 = snoop_kind;
      if (n0 >= 0 && n == n0 + 2) sk2 = snoop_kind;
      if (done[0] && n0 < 0) begin n0 = n; req_kind[1:0] = BUS_IDLE; end
      if (done[1]) begin n1 = n; f1 = fill_data; req_kind[3:2] = BUS_IDLE; end
    end
    check("arb:lat0", 32'(n0), 32'd5);
    check("arb:lat1", 32'(n1), 32'd11);
    check("arb:skind0", 32'(sk1), 32'hB);
    check("arb:skind1", 32'(sk2), 32'hD);
    check("arb:fill1", f1, 32'h0);

    // Preload mem[5] through a victim write-back, then read it.
    set_victim(0, 1'b1, 4'd5, 32'hCAFE0005);
    run_txn("pre5", 0, BUS_WRITE_MISS, 4'd0, 6, 32'h0, 1'b0);
    clear_side();
    run_txn("rd5", 0, BUS_READ_MISS, 4'd5, 5, 32'hCAFE0005, 1'b0);

    // Snooper abort with its own write-back.
    set_snooper(0, 1'b1, 32'h1234, 1'b1, 4'd9, 32'h1234);
    run_txn("abt9", 1, BUS_READ_MISS, 4'd9, 3, 32'h1234, 1'b1);
    clear_side();
    run_txn("rd9", 0, BUS_READ_MISS, 4'd9, 5, 32'h1234, 1'b0);

    // Write miss with both write-backs, fill sees the snooper's data.
    set_victim(1, 1'b1, 4'd6, 32'hAA);
    set_snooper(0, 1'b0, 32'h0, 1'b1, 4'd2, 32'hBB);
    run_txn("wm2", 1, BUS_WRITE_MISS, 4'd2, 7, 32'hBB, 1'b0);
    clear_side();
    run_txn("rd6", 0, BUS_READ_MISS, 4'd6, 5, 32'hAA, 1'b0);

    // Both write-backs to the same address: snooper value lands last.
    set_victim(0, 1'b1, 4'd3, 32'h11);
    set_snooper(1, 1'b0, 32'h0, 1'b1, 4'd3, 32'h22);
    run_txn("same3", 0, BUS_READ_MISS, 4'd3, 7, 32'h22, 1'b0);
    clear_side();

    // Invalidate ignores a snooper abort and returns zero.
    set_snooper(0, 1'b1, 32'h55, 1'b0, 4'd0, 32'h0);
    run_txn("inv4", 1, BUS_INVALIDATE, 4'd4, 2, 32'h0, 1'b0);
    clear_side();

    // Aborted read miss with no write-back.
    set_snooper(1, 1'b1, 32'h99, 1'b0, 4'd0, 32'h0);
    run_txn("abt7", 0, BUS_READ_MISS, 4'd7, 2, 32'h99, 1'b1);
    clear_side();

    // Reset during MEM after a victim write-back.
    set_victim(1, 1'b1, 4'd10, 32'h42);
    repeat (2) @(posedge clk);
    #1;
    req_kind[3:2] = BUS_READ_MISS;
    req_addr[7:4] = 4'd5;
    saw_done = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (done != 2'b00) saw_done = 1'b1;
    end
    check("rstmid:inmem", 32'(dbg_state), 32'(MEM));
    rst = 1'b1;
    @(negedge clk);
    if (done != 2'b00) saw_done = 1'b1;
    check_reset_outputs("rstmid");
    rst = 1'b0;
    req_kind = 4'hF;
    clear_side();
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (done != 2'b00) saw_done = 1'b1;
    end
    check("rstmid:nodone", 32'(saw_done), 32'h0);
    run_txn("clr5", 0, BUS_READ_MISS, 4'd5, 5, 32'h0, 1'b0);
    run_txn("clr10", 1, BUS_READ_MISS, 4'd10, 5, 32'h0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
